// File: rtl/column_sum_scheduler.sv
// Column-sum sweep scheduler: issues one column-sum job per column, waits for
// completion with a timeout, strobes the result write, and repeats for MAX_ITER sweeps.
//
// state | meaning
// IDLE  | no run active, waiting for start
// ISSUE | cs_start pulse for the selected column
// WAIT  | counting cycles until cs_done or timeout
// WRITE | wr_en pulse, advance column / sweep
// DONE  | run complete, final col_idx/iter_cnt held
// ERR   | column-sum path timed out, err held
module column_sum_scheduler #(
    parameter int NUM_COLS = 3,
    parameter int MAX_ITER = 2,
    parameter int TIMEOUT  = 15,
    parameter int IDX_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cs_done,
    output logic             cs_start,
    output logic [IDX_W-1:0] col_idx,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_addr,
    output logic [IDX_W-1:0] iter_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(NUM_COLS - 1);
    localparam logic [IDX_W-1:0]  LAST_ITER = IDX_W'(MAX_ITER - 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [IDX_W-1:0]  r_col_idx;
    logic [IDX_W-1:0]  r_iter_cnt;
    logic              r_cs_start;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_col_idx  <= '0;
            r_iter_cnt <= '0;
            r_cs_start <= 1'b0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cs_start <= 1'b0;
            r_wr_en    <= 1'b0;
            r_done     <= 1'b0;
            if (abort) begin
                r_state    <= S_IDLE;
                r_wait_cnt <= '0;
                r_col_idx  <= '0;
                r_iter_cnt <= '0;
                r_busy     <= 1'b0;
                r_err      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start) begin
                            r_state    <= S_ISSUE;
                            r_wait_cnt <= '0;
                            r_col_idx  <= '0;
                            r_iter_cnt <= '0;
                            r_err      <= 1'b0;
                            r_busy     <= 1'b1;
                            r_cs_start <= 1'b1;
                        end
                    end
                    S_ISSUE: begin
                        // the first WAIT cycle already counts as one cycle waited
                        r_state    <= S_WAIT;
                        r_wait_cnt <= WCNT_W'(1);
                    end
                    S_WAIT: begin
                        if (cs_done) begin
                            r_state <= S_WRITE;
                            r_wr_en <= 1'b1;
                        end else if (r_wait_cnt == WAIT_MAX) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                        end
                    end
                    S_WRITE: begin
                        if (r_col_idx != LAST_COL) begin
                            r_col_idx  <= r_col_idx + IDX_W'(1);
                            r_wait_cnt <= '0;
                            r_state    <= S_ISSUE;
                            r_cs_start <= 1'b1;
                        end else if (r_iter_cnt != LAST_ITER) begin
                            r_col_idx  <= '0;
                            r_iter_cnt <= r_iter_cnt + IDX_W'(1);
                            r_wait_cnt <= '0;
                            r_state    <= S_ISSUE;
                            r_cs_start <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cs_start = r_cs_start;
    assign col_idx  = r_col_idx;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_col_idx;
    assign iter_cnt = r_iter_cnt;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: doc/column_sum_scheduler.md
COLUMN_SUM_SCHEDULER -- requirements
Module: column_sum_scheduler

Interface
REQ-001 SHALL have parameter NUM_COLS, default 3: number of variable-node columns swept per iteration (min 2).
REQ-002 SHALL have parameter MAX_ITER, default 2: number of belief-propagation sweeps per run (min 1).
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum cycles spent in WAIT before an error is raised.
REQ-004 SHALL have parameter IDX_W, default 8: width of col_idx, wr_addr and iter_cnt.
REQ-005 SHALL have port clk, input, 1: single clock; all flops on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: run request, sampled only in IDLE, DONE or ERR.
REQ-008 SHALL have port abort, input, 1: synchronous cancel of the current run.
REQ-009 SHALL have port cs_done, input, 1: completion pulse from the column-sum control path.
REQ-010 SHALL have port cs_start, output, 1: one-cycle start pulse to the column-sum control path.
REQ-011 SHALL have port col_idx, output, IDX_W: column currently selected; it steers the r1/r2/r3 operand muxes.
REQ-012 SHALL have port wr_en, output, 1: one-cycle write strobe for the column-sum result memory.
REQ-013 SHALL have port wr_addr, output, IDX_W: result memory address; it equals col_idx while wr_en is high.
REQ-014 SHALL have port iter_cnt, output, IDX_W: current sweep number, starting at 0.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE, DONE and ERR.
REQ-016 SHALL have port done, output, 1: one-cycle pulse marking completion of the final sweep.
REQ-017 SHALL have port err, output, 1: timeout flag, held until the next accepted start.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, WAIT, WRITE, DONE and ERR.
REQ-019 SHALL move IDLE/DONE/ERR -> ISSUE on start=1, clearing col_idx, iter_cnt, err and the wait counter.
REQ-020 SHALL, in ISSUE, drive cs_start=1 for exactly one cycle, then move to WAIT.
REQ-021 SHALL, in WAIT, increment the wait counter each cycle; on cs_done=1 it moves to WRITE.
REQ-022 SHALL, in WAIT, move to ERR with err=1 once the wait counter reaches TIMEOUT without cs_done.
REQ-023 SHALL give cs_done priority when cs_done and timeout occur in the same cycle (-> WRITE, no error).
REQ-024 SHALL, in WRITE, drive wr_en=1 for one cycle with wr_addr=col_idx and then take exactly one of three transitions.
  - col_idx<NUM_COLS-1: col_idx+1, go to ISSUE.
  - last column, iter_cnt<MAX_ITER-1: col_idx=0, iter_cnt+1, go to ISSUE.
  - last column, last iteration: go to DONE.
REQ-025 SHALL assert done for the single cycle of entry into DONE, then remain in DONE with done=0 and col_idx/iter_cnt holding their final values.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL ignore cs_done outside WAIT.
REQ-028 SHALL, on abort=1 in any state, go to IDLE on the next edge: no wr_en, done or err, counters cleared; abort overrides start.
REQ-029 SHALL reset the wait counter on every entry to ISSUE.
REQ-030 SHALL issue exactly NUM_COLS*MAX_ITER cs_start pulses and NUM_COLS*MAX_ITER wr_en pulses per uninterrupted run.
REQ-031 SHALL keep end-to-end latency at 2 cycles of overhead per column (ISSUE+WRITE) plus the column-sum latency.
REQ-032 SHALL size the wait counter at ceil(log2(TIMEOUT+1)) bits, so it cannot wrap before reaching TIMEOUT.

Reset
REQ-033 SHALL, while rst_n=0, immediately force state IDLE and all outputs and counters to 0, independent of clk.
REQ-034 SHALL, on rst_n asserted mid-run, drop any in-flight cs_start or wr_en without completing it.
REQ-035 SHALL leave IDLE only on a start sampled on or after the first rising edge following rst_n deassertion.

Verification
REQ-036 SHALL cover a nominal run (defaults, cs_done returned 2 cycles after each cs_start, start pulsed once) -> 6 cs_start, 6 wr_en with wr_addr 0,1,2,0,1,2, iter_cnt 0->1, one done pulse, err=0.
REQ-037 SHALL cover a timeout: cs_done withheld on column 1 -> ERR 15 cycles after WAIT entry, err=1 held, busy=0, no done; a following start clears err and restarts at col 0.
REQ-038 SHALL cover a race: cs_done arriving exactly at wait count 15 -> WRITE taken, err stays 0.
REQ-039 SHALL cover abort during WAIT of column 2, iteration 1 -> IDLE next cycle, col_idx=0, iter_cnt=0, no wr_en or done.
REQ-040 SHALL cover spurious inputs: start pulsed in WAIT and cs_done pulsed in IDLE -> no state change and no extra cs_start or wr_en.
REQ-041 SHALL cover async reset: rst_n low mid-WRITE, between clock edges -> wr_en and all outputs 0 immediately; after release, state is IDLE until start.
